state_rf_arbiter: RTL and testbench
===================================

# state_rf_arbiter

Controller that owns the ports of the 17-bit, 4096-entry state regfile (one entry per InexRecur: call position 4 b, parent argument address 12 b, done flag 1 b). It accepts append-only state pushes, serves latency-critical random lookups, and runs background sequential scans of newly written entries. The regfile cannot perform a random read and a sequential read in the same cycle, so this block arbitrates those two accesses and guarantees the two read enables are never high together. It sits between the recursion engine (push and random lookup) and the writeback scanner (sequential scan).

## Interface
- STARVE_LIM, 4: maximum consecutive random-read grants while a scan step waits.
- DEPTH, 4096: number of regfile entries.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_valid / push_ready  in/out  1  push handshake.
- push_pos  in  4  call position; push_parent  in  12  parent argument address; push_done  in  1  done flag.
- ran_req_valid / ran_req_ready  in/out  1  random-lookup handshake; ran_req_addr  in  12.
- ran_rsp_valid  out  1; ran_rsp_data  out  17; ran_rsp_err  out  1.
- scan_start  in  1  request a scan; scan_busy  out  1.
- scan_data_valid  out  1; scan_data  out  17; scan_addr  out  12; scan_last  out  1; scan_done  out  1 (pulse).
- rf_we  out  1; rf_w_data  out  17 = {pos, parent, done}.
- rf_seq_re  out  1; rf_seq_r_data  in  17.
- rf_ran_re  out  1; rf_ran_r_addr  out  12; rf_ran_r_data  in  17; rf_r_addr  in  12.
- wr_total  out  13  number of entries written; full  out  1  (wr_total == DEPTH).

## Operation
- Regfile contract: write and sequential-read pointers start at 0 after reset and increment once per rf_we / rf_seq_re. Read data and rf_r_addr are valid the cycle after the enable.
- Push: push_ready = !full. On accept, register rf_we = 1 and rf_w_data for one cycle, and increment wr_total. At full, no pushes are accepted and wr_total saturates at 4096.
- Random lookup: addr >= wr_total gives an error response (ran_rsp_err = 1, data 0) at normal latency, and rf_ran_re is not asserted. Otherwise the regfile is read.
- Scan tracking: scanned (13 b) counts entries already delivered. pending = wr_total - scanned.
- Scan FSM states:
  - S_IDLE: on scan_start, latch N = pending. N = 0 goes to S_DONE. Otherwise go to S_RUN.
  - S_RUN: issue N rf_seq_re steps, then go to S_DONE once the final data has been returned.
  - S_DONE: pulse scan_done for 1 cycle, then go to S_IDLE.
  - scan_busy = (state != S_IDLE). scan_start is ignored while busy.
- Each returned entry produces scan_data_valid with scan_data = rf_seq_r_data and scan_addr = rf_r_addr. scan_last marks the N-th entry. scanned increments per delivered entry.
- Read-slot arbiter, evaluated each cycle:
  - A valid, accepted random request wins over a scan step.
  - A starvation counter counts consecutive random grants while S_RUN has steps left. When it reaches STARVE_LIM, the next slot is forced to scan: ran_req_ready = 0 for that cycle. The counter clears on any scan grant.
  - ran_req_ready = 1 otherwise, including in S_IDLE. Random lookups are fully pipelined at 1 per cycle.
- Pushes are independent of reads and may occur in the same cycle as either.
- Entries pushed during a scan are not part of that scan; they stay pending for the next scan.
- Invariant: rf_seq_re & rf_ran_re is never 1.

## Timing
- Push accepted at cycle t gives rf_we = 1 at t+1.
- Random request accepted at t gives rf_ran_re at t+1, then ran_rsp_valid / ran_rsp_data / ran_rsp_err registered at t+3. The error path also responds at t+3.
- Scan step granted at t gives rf_seq_re at t+1 and scan_data_valid at t+3.
- scan_done is asserted the cycle after the last scan_data_valid. For N = 0, scan_done occurs 2 cycles after scan_start.
- Responses are in order and there is no backpressure on responses.
- Reset values: all outputs 0, except push_ready = 1 and ran_req_ready = 1. wr_total = 0, scanned = 0, FSM in S_IDLE.
- Reset mid-scan or mid-lookup aborts all in-flight operations, with no partial response after reset release. The regfile must be reset by the same event.

## Test plan
- Push 3 entries, e.g. {4'h2, 12'h010, 1'b0}, at back-to-back cycles, then read addr 1 -> rf_we on 3 consecutive cycles; wr_total = 3; ran_rsp_data equals the second pushed value, err 0, 3 cycles after accept.
- Random read of addr 5 with wr_total = 3 -> ran_rsp_err = 1, data 0, rf_ran_re never asserted.
- 3 entries pending, scan_start -> 3 scan_data_valid with scan_addr 0, 1, 2, scan_last on addr 2, then a scan_done pulse; a second scan_start -> scan_done 2 cycles later with no data.
- Scan of 10 entries while a random request is held valid every cycle -> exactly 1 scan grant after every 4 random grants; rf_seq_re & rf_ran_re is never 1; the scan completes.
- Push 4096 entries -> full = 1, push_ready = 0; a 4097th push_valid is not accepted and wr_total stays 4096.
- Assert rst during S_RUN with 2 lookups in flight -> all outputs reach their reset values immediately; no ran_rsp_valid or scan_data_valid after release.

Source files
------------

// File: rtl/state_rf_arbiter.sv
// Port controller for the 17-bit x 4096 state regfile: append-only pushes, pipelined
// random lookups, and background sequential scans sharing a single read slot.
module state_rf_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int DEPTH      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [3:0]  push_pos,
  input  logic [11:0] push_parent,
  input  logic        push_done,
  input  logic        ran_req_valid,
  output logic        ran_req_ready,
  input  logic [11:0] ran_req_addr,
  output logic        ran_rsp_valid,
  output logic [16:0] ran_rsp_data,
  output logic        ran_rsp_err,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_data_valid,
  output logic [16:0] scan_data,
  output logic [11:0] scan_addr,
  output logic        scan_last,
  output logic        scan_done,
  output logic        rf_we,
  output logic [16:0] rf_w_data,
  output logic        rf_seq_re,
  input  logic [16:0] rf_seq_r_data,
  output logic        rf_ran_re,
  output logic [11:0] rf_ran_r_addr,
  input  logic [16:0] rf_ran_r_data,
  input  logic [11:0] rf_r_addr,
  output logic [12:0] wr_total,
  output logic        full
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [12:0] DEPTH_C = 13'(DEPTH);
  localparam logic [SW-1:0] LIM_C = SW'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [12:0]   wr_total_q, wr_total_d, scanned_q, scanned_d, steps_q, steps_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [16:0]   rf_w_data_q, rf_w_data_d;
  logic          rf_ran_re_q, rf_ran_re_d, ran_s1_err_q, ran_s1_err_d;
  logic [11:0]   rf_ran_r_addr_q, rf_ran_r_addr_d;
  logic          ran_s2_q, ran_s2_d, ran_s2_err_q, ran_s2_err_d;
  logic          ran_rsp_valid_q, ran_rsp_valid_d, ran_rsp_err_q, ran_rsp_err_d;
  logic [16:0]   ran_rsp_data_q, ran_rsp_data_d;
  logic          rf_seq_re_q, rf_seq_re_d, seq_s1_last_q, seq_s1_last_d;
  logic          seq_s2_q, seq_s2_d, seq_s2_last_q, seq_s2_last_d;
  logic          scan_data_valid_q, scan_data_valid_d, scan_last_q, scan_last_d;
  logic [16:0]   scan_data_q, scan_data_d;
  logic [11:0]   scan_addr_q, scan_addr_d;
  logic          scan_done_q, scan_done_d;

  logic        push_fire, run_pend, force_scan, ran_fire, ran_err, scan_grant;
  logic [12:0] pending;

  always_comb begin
    full          = (wr_total_q == DEPTH_C);
    push_fire     = push_valid & ~full;
    run_pend      = (state_q == S_RUN) && (steps_q != 13'd0);
    // After STARVE_LIM back-to-back lookups the waiting scan step takes the slot.
    force_scan    = run_pend && (starve_q == LIM_C);
    ran_req_ready = ~force_scan;
    ran_fire      = ran_req_valid & ran_req_ready;
    ran_err       = ({1'b0, ran_req_addr} >= wr_total_q);
    scan_grant    = run_pend & ~ran_fire;
    pending       = wr_total_q - scanned_q;

    wr_total_d    = wr_total_q + 13'(push_fire);
    rf_we_d       = push_fire;
    rf_w_data_d   = push_fire ? {push_pos, push_parent, push_done} : rf_w_data_q;

    rf_ran_re_d     = ran_fire & ~ran_err;
    ran_s1_err_d    = ran_fire & ran_err;
    rf_ran_r_addr_d = ran_fire ? ran_req_addr : rf_ran_r_addr_q;
    ran_s2_d        = rf_ran_re_q | ran_s1_err_q;
    ran_s2_err_d    = ran_s1_err_q;
    ran_rsp_valid_d = ran_s2_q;
    ran_rsp_err_d   = ran_s2_q & ran_s2_err_q;
    ran_rsp_data_d  = (ran_s2_q && !ran_s2_err_q) ? rf_ran_r_data : 17'd0;

    rf_seq_re_d       = scan_grant;
    seq_s1_last_d     = scan_grant && (steps_q == 13'd1);
    seq_s2_d          = rf_seq_re_q;
    seq_s2_last_d     = rf_seq_re_q & seq_s1_last_q;
    scan_data_valid_d = seq_s2_q;
    scan_last_d       = seq_s2_q & seq_s2_last_q;
    scan_data_d       = seq_s2_q ? rf_seq_r_data : scan_data_q;
    scan_addr_d       = seq_s2_q ? rf_r_addr : scan_addr_q;
    scanned_d         = scanned_q + 13'(seq_s2_q);

    steps_d     = steps_q - 13'(scan_grant);
    starve_d    = (run_pend && ran_fire) ? starve_q + SW'(1) : '0;
    scan_done_d = (state_q == S_DONE);
    state_d     = state_q;
    unique case (state_q)
      S_IDLE: if (scan_start) begin
        steps_d = pending;
        state_d = (pending == 13'd0) ? S_DONE : S_RUN;
      end
      S_RUN:   if (seq_s2_q && seq_s2_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      wr_total_q        <= '0;
      scanned_q         <= '0;
      steps_q           <= '0;
      starve_q          <= '0;
      rf_we_q           <= 1'b0;
      rf_w_data_q       <= '0;
      rf_ran_re_q       <= 1'b0;
      ran_s1_err_q      <= 1'b0;
      rf_ran_r_addr_q   <= '0;
      ran_s2_q          <= 1'b0;
      ran_s2_err_q      <= 1'b0;
      ran_rsp_valid_q   <= 1'b0;
      ran_rsp_err_q     <= 1'b0;
      ran_rsp_data_q    <= '0;
      rf_seq_re_q       <= 1'b0;
      seq_s1_last_q     <= 1'b0;
      seq_s2_q          <= 1'b0;
      seq_s2_last_q     <= 1'b0;
      scan_data_valid_q <= 1'b0;
      scan_last_q       <= 1'b0;
      scan_data_q       <= '0;
      scan_addr_q       <= '0;
      scan_done_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_total_q        <= wr_total_d;
      scanned_q         <= scanned_d;
      steps_q           <= steps_d;
      starve_q          <= starve_d;
      rf_we_q           <= rf_we_d;
      rf_w_data_q       <= rf_w_data_d;
      rf_ran_re_q       <= rf_ran_re_d;
      ran_s1_err_q      <= ran_s1_err_d;
      rf_ran_r_addr_q   <= rf_ran_r_addr_d;
      ran_s2_q          <= ran_s2_d;
      ran_s2_err_q      <= ran_s2_err_d;
      ran_rsp_valid_q   <= ran_rsp_valid_d;
      ran_rsp_err_q     <= ran_rsp_err_d;
      ran_rsp_data_q    <= ran_rsp_data_d;
      rf_seq_re_q       <= rf_seq_re_d;
      seq_s1_last_q     <= seq_s1_last_d;
      seq_s2_q          <= seq_s2_d;
      seq_s2_last_q     <= seq_s2_last_d;
      scan_data_valid_q <= scan_data_valid_d;
      scan_last_q       <= scan_last_d;
      scan_data_q       <= scan_data_d;
      scan_addr_q       <= scan_addr_d;
      scan_done_q       <= scan_done_d;
    end
  end

  assign push_ready      = ~full;
  assign wr_total        = wr_total_q;
  assign rf_we           = rf_we_q;
  assign rf_w_data       = rf_w_data_q;
  assign rf_ran_re       = rf_ran_re_q;
  assign rf_ran_r_addr   = rf_ran_r_addr_q;
  assign rf_seq_re       = rf_seq_re_q;
  assign ran_rsp_valid   = ran_rsp_valid_q;
  assign ran_rsp_data    = ran_rsp_data_q;
  assign ran_rsp_err     = ran_rsp_err_q;
  assign scan_busy       = (state_q != S_IDLE);
  assign scan_data_valid = scan_data_valid_q;
  assign scan_data       = scan_data_q;
  assign scan_addr       = scan_addr_q;
  assign scan_last       = scan_last_q;
  assign scan_done       = scan_done_q;
endmodule

// File: tb/tb_state_rf_arbiter.sv
// Bench for state_rf_arbiter: regfile model, per-cycle observation queues and a
// scoreboard built from pushed values, with directed and randomized scenarios.
module tb_state_rf_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic push_valid = 0, push_ready, push_done = 0;
  logic [3:0] push_pos = 0;
  logic [11:0] push_parent = 0;
  logic ran_req_valid = 0, ran_req_ready;
  logic [11:0] ran_req_addr = 0;
  logic ran_rsp_valid, ran_rsp_err;
  logic [16:0] ran_rsp_data;
  logic scan_start = 0, scan_busy, scan_data_valid, scan_last, scan_done;
  logic [16:0] scan_data;
  logic [11:0] scan_addr;
  logic rf_we, rf_seq_re, rf_ran_re, full;
  logic [16:0] rf_w_data, rf_seq_r_data, rf_ran_r_data;
  logic [11:0] rf_ran_r_addr, rf_r_addr;
  logic [12:0] wr_total;

  state_rf_arbiter dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_pos(push_pos),
    .push_parent(push_parent), .push_done(push_done),
    .ran_req_valid(ran_req_valid), .ran_req_ready(ran_req_ready), .ran_req_addr(ran_req_addr),
    .ran_rsp_valid(ran_rsp_valid), .ran_rsp_data(ran_rsp_data), .ran_rsp_err(ran_rsp_err),
    .scan_start(scan_start), .scan_busy(scan_busy),
    .scan_data_valid(scan_data_valid), .scan_data(scan_data), .scan_addr(scan_addr),
    .scan_last(scan_last), .scan_done(scan_done),
    .rf_we(rf_we), .rf_w_data(rf_w_data),
    .rf_seq_re(rf_seq_re), .rf_seq_r_data(rf_seq_r_data),
    .rf_ran_re(rf_ran_re), .rf_ran_r_addr(rf_ran_r_addr), .rf_ran_r_data(rf_ran_r_data),
    .rf_r_addr(rf_r_addr), .wr_total(wr_total), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Regfile: write / sequential pointers, read data one cycle after enable.
  logic [16:0] rf_mem [4096];
  int wp, sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= 0; sp <= 0; rf_seq_r_data <= '0; rf_ran_r_data <= '0; rf_r_addr <= '0;
    end else begin
      if (rf_we) begin rf_mem[wp[11:0]] <= rf_w_data; wp <= wp + 1; end
      if (rf_ran_re) rf_ran_r_data <= rf_mem[rf_ran_r_addr];
      if (rf_seq_re) begin rf_seq_r_data <= rf_mem[sp[11:0]]; rf_r_addr <= sp[11:0]; sp <= sp + 1; end
    end
  end

  typedef struct { int cyc; logic [16:0] data; logic err; } rsp_t;
  typedef struct { int cyc; logic [16:0] data; logic [11:0] addr; logic last; } sd_t;
  typedef struct { int cyc; int n; int base; } scan_t;

  rsp_t exp_rsp[$], obs_rsp[$];
  sd_t obs_scan[$];
  scan_t scans[$];
  int obs_done[$], we_cyc[$], seq_re_cyc[$];
  int overlap_cnt = 0, busy_bad = 0;
  int m_wr = 0, m_scanned = 0;
  bit m_busy = 0;
  logic [16:0] m_mem [4096];
  int n_cmp = 0, n_fail = 0;

  task automatic clear_obs();
    exp_rsp.delete(); obs_rsp.delete(); obs_scan.delete(); scans.delete();
    obs_done.delete(); we_cyc.delete(); seq_re_cyc.delete();
    overlap_cnt = 0; busy_bad = 0;
  endtask

  // Observation and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      clear_obs(); m_wr = 0; m_scanned = 0; m_busy = 0;
    end else begin
      if (rf_seq_re && rf_ran_re) overlap_cnt++;
      if (rf_we) we_cyc.push_back(cyc);
      if (rf_seq_re) seq_re_cyc.push_back(cyc);
      if (ran_rsp_valid) obs_rsp.push_back('{cyc, ran_rsp_data, ran_rsp_err});
      if (scan_data_valid) obs_scan.push_back('{cyc, scan_data, scan_addr, scan_last});
      if (scan_done) begin obs_done.push_back(cyc); m_busy = 0; end
      if (scan_busy !== m_busy) busy_bad++;
      if (ran_req_valid && ran_req_ready) begin
        if (int'(ran_req_addr) >= m_wr) exp_rsp.push_back('{cyc + 3, 17'd0, 1'b1});
        else exp_rsp.push_back('{cyc + 3, m_mem[ran_req_addr], 1'b0});
      end
      if (scan_start && !m_busy) begin
        scans.push_back('{cyc, m_wr - m_scanned, m_scanned});
        m_scanned = m_wr; m_busy = 1;
      end
      if (push_valid && m_wr < 4096) begin
        m_mem[m_wr[11:0]] = {push_pos, push_parent, push_done};
        m_wr++;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic test_reset();
    logic [11:0] ctl;
    logic [87:0] dat;
    #1;
    ctl = {push_ready, ran_req_ready, scan_busy, full, rf_we, rf_seq_re, rf_ran_re,
           ran_rsp_valid, ran_rsp_err, scan_data_valid, scan_last, scan_done};
    dat = {wr_total, ran_rsp_data, scan_data, scan_addr, rf_w_data, rf_ran_r_addr};
    n_cmp++; if (ctl !== 12'b1100_0000_0000) begin n_fail++; $display("FAIL reset_ctl got %b want 110000000000", ctl); end
    n_cmp++; if (dat !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", dat); end
  endtask

  task automatic test_push_lookup();
    logic [16:0] v [3];
    int p, a;
    v[0] = {4'h2, 12'h010, 1'b0}; v[1] = {4'h5, 12'hABC, 1'b1}; v[2] = {4'hF, 12'h001, 1'b1};
    clear_obs();
    p = cyc;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1; {push_pos, push_parent, push_done} = v[i]; tick();
    end
    push_valid = 0;
    a = cyc; ran_req_valid = 1; ran_req_addr = 12'd1; tick(); ran_req_valid = 0;
    repeat (5) tick();
    n_cmp++; if (we_cyc.size() != 3 || we_cyc[0] != p + 1 || we_cyc[2] != p + 3) begin
      n_fail++; $display("FAIL push_we count=%0d first=%0d want 3 from %0d", we_cyc.size(),
                         we_cyc.size() ? we_cyc[0] : -1, p + 1); end
    n_cmp++; if (wr_total !== 13'd3) begin n_fail++; $display("FAIL push_wr_total got %0d want 3", wr_total); end
    n_cmp++; if (obs_rsp.size() != 1 || obs_rsp[0].cyc != a + 3 || obs_rsp[0].data !== v[1] || obs_rsp[0].err !== 1'b0) begin
      n_fail++; $display("FAIL lookup_addr1 n=%0d cyc=%0d data=%h err=%b want cyc=%0d data=%h err=0", obs_rsp.size(),
                         obs_rsp.size() ? obs_rsp[0].cyc : -1, obs_rsp.size() ? obs_rsp[0].data : 17'h0,
                         obs_rsp.size() ? obs_rsp[0].err : 1'bx, a + 3, v[1]); end
  endtask

  task automatic test_err_read();
    int a;
    clear_obs();
    a = cyc; ran_req_valid = 1; ran_req_addr = 12'd5; tick(); ran_req_valid = 0;
    repeat (5) tick();
    n_cmp++; if (obs_rsp.size() != 1 || obs_rsp[0].cyc != a + 3 || obs_rsp[0].data !== 17'd0 || obs_rsp[0].err !== 1'b1) begin
      n_fail++; $display("FAIL err_read n=%0d cyc=%0d err=%b want cyc=%0d err=1 data=0", obs_rsp.size(),
                         obs_rsp.size() ? obs_rsp[0].cyc : -1, obs_rsp.size() ? obs_rsp[0].err : 1'bx, a + 3); end
    n_cmp++; if (rf_ran_re !== 1'b0 || exp_rsp.size() != 1 || overlap_cnt != 0 || we_cyc.size() != 0) begin
      n_fail++; $display("FAIL err_read_side rf_ran_re=%b exp=%0d want 0 and 1 expected response", rf_ran_re, exp_rsp.size()); end
  endtask

  task automatic test_scan();
    int s, s2, bad;
    clear_obs();
    s = cyc; scan_start = 1; tick(); scan_start = 0; tick();
    scan_start = 1; tick(); scan_start = 0;  // ignored: scan in progress
    for (int i = 0; i < 30 && obs_done.size() == 0; i++) tick();
    repeat (2) tick();
    n_cmp++; if (obs_scan.size() != 3) begin n_fail++; $display("FAIL scan3_count got %0d want 3", obs_scan.size()); end
    bad = 0;
    for (int j = 0; j < 3 && j < obs_scan.size(); j++)
      if (obs_scan[j].addr !== 12'(j) || obs_scan[j].data !== m_mem[j] || obs_scan[j].last !== (j == 2)) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL scan3_entries bad=%0d want 0", bad); end
    n_cmp++; if (obs_scan.size() == 0 || obs_scan[0].cyc != s + 4) begin
      n_fail++; $display("FAIL scan3_latency got %0d want %0d", obs_scan.size() ? obs_scan[0].cyc : -1, s + 4); end
    n_cmp++; if (obs_done.size() != 1 || obs_done[0] != s + 7) begin
      n_fail++; $display("FAIL scan3_done n=%0d cyc=%0d want 1 at %0d", obs_done.size(),
                         obs_done.size() ? obs_done[0] : -1, s + 7); end
    clear_obs();
    s2 = cyc; scan_start = 1; tick(); scan_start = 0;
    repeat (4) tick();
    n_cmp++; if (obs_scan.size() != 0 || obs_done.size() != 1 || obs_done[0] != s2 + 2) begin
      n_fail++; $display("FAIL scan0_done data=%0d n=%0d cyc=%0d want 0 data, done at %0d", obs_scan.size(),
                         obs_done.size(), obs_done.size() ? obs_done[0] : -1, s2 + 2); end
  endtask

  task automatic test_starve();
    int s, bad;
    for (int i = 0; i < 10; i++) begin
      push_valid = 1; push_pos = 4'($urandom); push_parent = 12'($urandom); push_done = 1'($urandom); tick();
    end
    push_valid = 0; tick();
    clear_obs();
    s = cyc; scan_start = 1; ran_req_valid = 1; ran_req_addr = 12'($urandom_range(0, 12)); tick();
    scan_start = 0;
    for (int i = 0; i < 120 && obs_done.size() == 0; i++) begin
      ran_req_addr = 12'($urandom_range(0, 12)); tick();
    end
    ran_req_valid = 0;
    repeat (5) tick();
    n_cmp++; if (seq_re_cyc.size() != 10 || seq_re_cyc[0] != s + 6) begin
      n_fail++; $display("FAIL starve_steps n=%0d first=%0d want 10 from %0d", seq_re_cyc.size(),
                         seq_re_cyc.size() ? seq_re_cyc[0] : -1, s + 6); end
    bad = 0;
    for (int i = 1; i < seq_re_cyc.size(); i++) if (seq_re_cyc[i] - seq_re_cyc[i-1] != 5) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL starve_ratio bad_gaps=%0d want 0", bad); end
    n_cmp++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL starve_overlap got %0d want 0", overlap_cnt); end
    n_cmp++; if (obs_done.size() != 1 || obs_done[0] != s + 54) begin
      n_fail++; $display("FAIL starve_done n=%0d cyc=%0d want 1 at %0d", obs_done.size(),
                         obs_done.size() ? obs_done[0] : -1, s + 54); end
    bad = 0;
    for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
      if (obs_rsp[i].cyc != exp_rsp[i].cyc || obs_rsp[i].data !== exp_rsp[i].data || obs_rsp[i].err !== exp_rsp[i].err) bad++;
    n_cmp++; if (bad != 0 || obs_rsp.size() != exp_rsp.size()) begin
      n_fail++; $display("FAIL starve_rsps got %0d (bad %0d) want %0d", obs_rsp.size(), bad, exp_rsp.size()); end
  endtask

  task automatic test_random();
    int k, lim;
    clear_obs();
    for (int c = 0; c < 400; c++) begin
      push_valid = 1'($urandom); push_pos = 4'($urandom); push_parent = 12'($urandom); push_done = 1'($urandom);
      lim = (m_wr + 3 > 4095) ? 4095 : m_wr + 3;
      ran_req_valid = 1'($urandom); ran_req_addr = 12'($urandom_range(0, lim));
      scan_start = !m_busy && ($urandom_range(0, 5) == 0);
      tick();
    end
    push_valid = 0; ran_req_valid = 0; scan_start = 0;
    for (int i = 0; i < 600 && m_busy; i++) tick();
    repeat (6) tick();
    for (int i = 0; i < exp_rsp.size(); i++) begin
      n_cmp++;
      if (i >= obs_rsp.size() || obs_rsp[i].cyc != exp_rsp[i].cyc || obs_rsp[i].data !== exp_rsp[i].data ||
          obs_rsp[i].err !== exp_rsp[i].err) begin
        n_fail++; $display("FAIL rnd_rsp[%0d] got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b", i,
                           i < obs_rsp.size() ? obs_rsp[i].cyc : -1, i < obs_rsp.size() ? obs_rsp[i].data : 17'h0,
                           i < obs_rsp.size() ? obs_rsp[i].err : 1'bx, exp_rsp[i].cyc, exp_rsp[i].data, exp_rsp[i].err);
      end
    end
    n_cmp++; if (obs_rsp.size() != exp_rsp.size()) begin n_fail++; $display("FAIL rnd_rsp_count got %0d want %0d", obs_rsp.size(), exp_rsp.size()); end
    k = 0;
    for (int s = 0; s < scans.size(); s++) begin
      int bad, done_want;
      bad = 0;
      done_want = scans[s].cyc + 2;
      for (int j = 0; j < scans[s].n; j++, k++) begin
        if (k >= obs_scan.size()) begin bad++; break; end
        if (obs_scan[k].data !== m_mem[scans[s].base + j] || obs_scan[k].addr !== 12'(scans[s].base + j) ||
            obs_scan[k].last !== (j == scans[s].n - 1)) bad++;
        done_want = obs_scan[k].cyc + 1;
      end
      n_cmp++;
      if (bad != 0 || s >= obs_done.size() || obs_done[s] != done_want) begin
        n_fail++; $display("FAIL rnd_scan[%0d] n=%0d bad=%0d done=%0d want done=%0d", s, scans[s].n, bad,
                           s < obs_done.size() ? obs_done[s] : -1, done_want);
      end
    end
    n_cmp++; if (obs_scan.size() != k || obs_done.size() != scans.size()) begin
      n_fail++; $display("FAIL rnd_scan_count got %0d/%0d want %0d/%0d", obs_scan.size(), obs_done.size(), k, scans.size()); end
    n_cmp++; if (overlap_cnt != 0 || busy_bad != 0) begin
      n_fail++; $display("FAIL rnd_invariants overlap=%0d busy_bad=%0d want 0/0", overlap_cnt, busy_bad); end
  endtask

  task automatic test_full();
    int n0, a;
    clear_obs();
    n0 = m_wr;
    for (int i = 0; i < 4096 - n0 + 4; i++) begin
      push_valid = 1; push_pos = 4'($urandom); push_parent = 12'($urandom); push_done = 1'($urandom); tick();
    end
    push_valid = 0;
    a = cyc; ran_req_valid = 1; ran_req_addr = 12'd4095; tick(); ran_req_valid = 0;
    repeat (4) tick();
    n_cmp++; if (full !== 1'b1 || push_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags full=%b ready=%b want 1/0", full, push_ready); end
    n_cmp++; if (wr_total !== 13'd4096) begin n_fail++; $display("FAIL full_wr_total got %0d want 4096", wr_total); end
    n_cmp++; if (we_cyc.size() != 4096 - n0) begin n_fail++; $display("FAIL full_writes got %0d want %0d", we_cyc.size(), 4096 - n0); end
    n_cmp++; if (obs_rsp.size() != 1 || obs_rsp[0].cyc != a + 3 || obs_rsp[0].data !== m_mem[4095] || obs_rsp[0].err !== 1'b0) begin
      n_fail++; $display("FAIL full_last_read data=%h want %h", obs_rsp.size() ? obs_rsp[0].data : 17'h0, m_mem[4095]); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ctl;
    logic [87:0] dat;
    for (int i = 0; i < 100 && m_busy; i++) tick();
    clear_obs();
    scan_start = 1; tick(); scan_start = 0;
    ran_req_valid = 1; ran_req_addr = 12'd7; tick();
    ran_req_addr = 12'd9; tick(); ran_req_valid = 0;
    n_cmp++; if (scan_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy got %b want 1", scan_busy); end
    #2 rst = 1;
    #1;
    ctl = {push_ready, ran_req_ready, scan_busy, full, rf_we, rf_seq_re, rf_ran_re,
           ran_rsp_valid, ran_rsp_err, scan_data_valid, scan_last, scan_done};
    dat = {wr_total, ran_rsp_data, scan_data, scan_addr, rf_w_data, rf_ran_r_addr};
    n_cmp++; if (ctl !== 12'b1100_0000_0000) begin n_fail++; $display("FAIL midrst_ctl got %b want 110000000000", ctl); end
    n_cmp++; if (dat !== '0) begin n_fail++; $display("FAIL midrst_data got %h want 0", dat); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (10) tick();
    n_cmp++; if (obs_rsp.size() != 0 || obs_scan.size() != 0 || obs_done.size() != 0 || wr_total !== 13'd0) begin
      n_fail++; $display("FAIL midrst_after rsp=%0d scan=%0d done=%0d wr=%0d want all 0", obs_rsp.size(),
                         obs_scan.size(), obs_done.size(), wr_total); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1 rst = 0;
    tick();
    test_push_lookup();
    test_err_read();
    test_scan();
    test_starve();
    test_random();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
